// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian host byte stream into 32-bit words and writes them to instruction memory.
// Define IMEM_LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte after the image.
module imem_loader #(
    parameter int ADDR_WIDTH = 11,
    parameter int MAX_WORDS  = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam logic [2:0] IDLE = 3'd0, LEN_LO = 3'd1, LEN_HI = 3'd2, DATA = 3'd3, WRITE = 3'd4, DONE = 3'd5;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0] CHECK = 3'd6;
    localparam logic [2:0] FINAL = CHECK;
    logic [7:0] csum;
`else
    localparam logic [2:0] FINAL = DONE;
`endif
    logic [2:0]            state;
    logic [15:0]           len, count, n;
    logic [ADDR_WIDTH-1:0] addr;
    logic [23:0]           shift;
    logic [1:0]            byte_idx;
    logic                  xfer;

    assign byte_ready = state == LEN_LO || state == LEN_HI || state == DATA
`ifdef IMEM_LOADER_CHECKSUM_EN
                        || state == CHECK
`endif
                        ;
    assign xfer     = byte_valid && byte_ready;
    assign mem_we   = state == WRITE;
    assign busy     = state != IDLE && state != DONE;
    assign cpu_hold = busy;
    assign done     = state == DONE;
    assign n        = {byte_data, len[7:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            len       <= '0;
            count     <= '0;
            addr      <= '0;
            shift     <= '0;
            byte_idx  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            error     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state    <= LEN_LO;
                    error    <= 1'b0;
                    count    <= '0;
                    addr     <= '0;
                    byte_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum     <= '0;
`endif
                end
                LEN_LO: if (xfer) begin
                    len[7:0] <= byte_data;
                    state    <= LEN_HI;
                end
                LEN_HI: if (xfer) begin
                    len[15:8] <= byte_data;
                    count     <= '0;
                    addr      <= '0;
                    byte_idx  <= '0;
                    if (n > 16'(MAX_WORDS)) begin
                        error <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= n == 16'd0 ? FINAL : DATA;
                    end
                end
                DATA: if (xfer) begin
                    // Bytes enter at the top so after three shifts the low 24 bits hold b2:b1:b0.
                    shift    <= {byte_data, shift[23:8]};
                    byte_idx <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum     <= csum ^ byte_data;
`endif
                    if (byte_idx == 2'd3) begin
                        mem_addr  <= addr;
                        mem_wdata <= {byte_data, shift};
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    addr  <= addr + ADDR_WIDTH'(4);
                    count <= count + 16'd1;
                    state <= count + 16'd1 == len ? FINAL : DATA;
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHECK: if (xfer) begin
                    error <= byte_data != csum;
                    state <= DONE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized load scenarios checked against a queue-based model of the expected memory writes.
module tb_imem_loader;
    localparam int AW = 11;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic byte_ready, mem_we, cpu_hold, busy, done, error;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata;
    int tests = 0, fails = 0, cyc = 0, hold_bad = 0;
    logic [31:0] words[$];
    int exp_cyc[$], got_cyc[$];
    logic [AW-1:0] got_addr[$];
    logic [31:0] got_data[$];
    logic got_rdy[$];

    imem_loader dut (
        .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (!reset) begin
        if (mem_we) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_wdata);
            got_cyc.push_back(cyc);
            got_rdy.push_back(byte_ready);
        end
        if (busy && !cpu_hold) hold_bad++;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic clear;
        got_addr.delete(); got_data.delete(); got_cyc.delete(); got_rdy.delete();
        exp_cyc.delete(); words.delete(); hold_bad = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, output int xc);
        int t = 0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data = b;
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        xc = cyc;
        if (!byte_ready) begin
            tests++; fails++;
            $display("FAIL byte_timeout ready=%b want 1", byte_ready);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    // Host-side driver: start pulse, length, LSB-first data, optional checksum (xor-ed with cbad to corrupt it).
    task automatic load(input int n, input int gap, input int poke, input logic [7:0] cbad);
        logic [7:0] cs = 8'h00, b;
        logic [31:0] w;
        int xc;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        send_byte(n[7:0], $urandom_range(gap, 0), xc);
        send_byte(n[15:8], $urandom_range(gap, 0), xc);
        if (n <= 512) begin
            for (int i = 0; i < n * 4; i++) begin
                if (i == poke) begin
                    start = 1'b1; @(negedge clk); start = 1'b0;
                end
                w = words[i / 4];
                b = w[8 * (i % 4) +: 8];
                cs ^= b;
                send_byte(b, $urandom_range(gap, 0), xc);
                if (i % 4 == 3) exp_cyc.push_back(xc + 1);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            send_byte(cs ^ cbad, $urandom_range(gap, 0), xc);
`else
            xc = int'(cs ^ cbad);
`endif
        end
        for (int t = 0; t < 20 && !done; t++) @(negedge clk);
    endtask

    task automatic test_reset;
        int xc;
        #1;
        tests++;
        if ({byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error} !== '0) begin
            fails++;
            $display("FAIL reset_init got %h want 0", {byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error});
        end
        @(negedge clk); reset = 1'b0;
        clear();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        send_byte(8'h01, 0, xc); send_byte(8'h00, 0, xc);
        send_byte(8'h13, 0, xc); send_byte(8'h01, 0, xc);
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error} !== '0) begin
            fails++;
            $display("FAIL reset_mid_data got %h want 0", {byte_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error});
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if (got_addr.size() != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_abandon writes=%0d busy=%b want 0/0", got_addr.size(), busy);
        end
    endtask

    task automatic test_single;
        clear();
        words.push_back(32'h00500113);
        load(1, 0, -1, 8'h00);
        tests++;
        if (got_addr.size() != 1 || got_addr[0] !== AW'(0) || got_data[0] !== 32'h00500113) begin
            fails++;
            $display("FAIL single_write count=%0d addr=%h data=%h want 1/0/00500113", got_addr.size(), got_addr[0], got_data[0]);
        end
        tests++;
        if ({done, error, cpu_hold, busy} !== 4'b1000) begin
            fails++;
            $display("FAIL single_status got %b want 1000", {done, error, cpu_hold, busy});
        end
    endtask

    task automatic test_multi;
        clear();
        words = '{32'h00500113, 32'h00C00193, 32'hFF718393};
        load(3, 0, -1, 8'h00);
        tests++;
        if (got_addr.size() != 3) begin
            fails++;
            $display("FAIL multi_count got %0d want 3", got_addr.size());
        end
        for (int i = 0; i < got_addr.size() && i < 3; i++) begin
            tests++;
            if (got_addr[i] !== AW'(i * 4) || got_data[i] !== words[i]) begin
                fails++;
                $display("FAIL multi_word%0d got %h/%h want %h/%h", i, got_addr[i], got_data[i], AW'(i * 4), words[i]);
            end
        end
        tests++;
        if (hold_bad != 0 || {done, cpu_hold} !== 2'b10) begin
            fails++;
            $display("FAIL multi_hold drops=%0d done/hold=%b want 0/10", hold_bad, {done, cpu_hold});
        end
    endtask

    task automatic test_gaps;
        clear();
        repeat (2) words.push_back($urandom);
        load(2, 3, -1, 8'h00);
        tests++;
        if (got_addr.size() != 2) begin
            fails++;
            $display("FAIL gaps_count got %0d want 2", got_addr.size());
        end
        for (int i = 0; i < got_addr.size() && i < 2; i++) begin
            tests++;
            if (got_addr[i] !== AW'(i * 4) || got_data[i] !== words[i] || got_cyc[i] != exp_cyc[i] || got_rdy[i] !== 1'b0) begin
                fails++;
                $display("FAIL gaps_word%0d got %h/%h cyc%0d rdy%b want %h/%h cyc%0d rdy0",
                         i, got_addr[i], got_data[i], got_cyc[i], got_rdy[i], AW'(i * 4), words[i], exp_cyc[i]);
            end
        end
    endtask

    task automatic test_zero;
        clear();
        load(0, 0, -1, 8'h00);
        tests++;
        if (got_addr.size() != 0 || {done, error, busy} !== 3'b100) begin
            fails++;
            $display("FAIL zero_len writes=%0d done/err/busy=%b want 0/100", got_addr.size(), {done, error, busy});
        end
    endtask

    task automatic test_overflow;
        clear();
        load(513, 0, -1, 8'h00);
        tests++;
        if (got_addr.size() != 0 || {done, error, busy} !== 3'b110) begin
            fails++;
            $display("FAIL overflow writes=%0d done/err/busy=%b want 0/110", got_addr.size(), {done, error, busy});
        end
        byte_valid = 1'b1;
        byte_data = 8'hA5;
        repeat (3) @(negedge clk);
        tests++;
        if (byte_ready !== 1'b0 || done !== 1'b1) begin
            fails++;
            $display("FAIL done_no_accept ready=%b done=%b want 0/1", byte_ready, done);
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_restart;
        clear();
        words.push_back($urandom);
        load(1, 1, -1, 8'h00);
        tests++;
        if (got_addr.size() != 1 || got_addr[0] !== AW'(0) || got_data[0] !== words[0] || error !== 1'b0 || done !== 1'b1) begin
            fails++;
            $display("FAIL restart count=%0d addr=%h data=%h err=%b done=%b want 1/0/%h/0/1",
                     got_addr.size(), got_addr[0], got_data[0], error, done, words[0]);
        end
    endtask

    task automatic test_max;
        int bad = 0;
        clear();
        repeat (512) words.push_back($urandom);
        load(512, 0, -1, 8'h00);
        tests++;
        if (got_addr.size() != 512 || got_addr[got_addr.size() - 1] !== AW'(2044)) begin
            fails++;
            $display("FAIL max_last count=%0d addr=%0d want 512/2044", got_addr.size(), got_addr[got_addr.size() - 1]);
        end
        for (int i = 0; i < got_addr.size() && i < 512; i++) begin
            tests++;
            if (got_addr[i] !== AW'(i * 4) || got_data[i] !== words[i]) begin
                fails++;
                if (bad++ < 4) $display("FAIL max_word%0d got %h/%h want %h/%h", i, got_addr[i], got_data[i], AW'(i * 4), words[i]);
            end
        end
    endtask

    task automatic test_start_ignored;
        clear();
        repeat (2) words.push_back($urandom);
        load(2, 1, 2, 8'h00);
        tests++;
        if (got_addr.size() != 2) begin
            fails++;
            $display("FAIL start_busy_count got %0d want 2", got_addr.size());
        end
        for (int i = 0; i < got_addr.size() && i < 2; i++) begin
            tests++;
            if (got_addr[i] !== AW'(i * 4) || got_data[i] !== words[i]) begin
                fails++;
                $display("FAIL start_busy_word%0d got %h/%h want %h/%h", i, got_addr[i], got_data[i], AW'(i * 4), words[i]);
            end
        end
        tests++;
        if (hold_bad != 0 || done !== 1'b1) begin
            fails++;
            $display("FAIL start_busy_status drops=%0d done=%b want 0/1", hold_bad, done);
        end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        clear();
        words.push_back(32'h00500113);
        load(1, 0, -1, 8'h00);
        tests++;
        if ({done, error} !== 2'b10) begin
            fails++;
            $display("FAIL csum_good done/err=%b want 10", {done, error});
        end
        load(1, 0, -1, 8'h42);
        tests++;
        if ({done, error} !== 2'b11) begin
            fails++;
            $display("FAIL csum_bad done/err=%b want 11", {done, error});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_gaps();
        test_zero();
        test_overflow();
        test_restart();
        test_max();
        test_start_ignored();
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. Receives a byte stream from a host link (UART/debug front end), assembles little-endian 32-bit instruction words, and issues single-cycle write strobes into the instruction memory array.
- Word addresses are byte addresses stepping by 4 (0, 4, 8, ...), which matches how the fetch side indexes instructions.
- Holds the core in reset (cpu_hold) while a program image is being loaded.

Parameters:
- ADDR_WIDTH, 11, width of the instruction-memory byte address.
- MAX_WORDS, 512, largest accepted image in words; must be ≤ 2^ADDR_WIDTH/4.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load. Ignored unless the FSM is in IDLE or DONE.
- byte_valid  in  1  host presents byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle (transfer = byte_valid & byte_ready).
- mem_we  out  1  write strobe to instruction memory, one cycle per word.
- mem_addr  out  ADDR_WIDTH  byte address of the word being written; always a multiple of 4.
- mem_wdata  out  32  assembled instruction word.
- cpu_hold  out  1  high from start accepted until DONE is reached; holds the core in reset.
- busy  out  1  FSM not in IDLE/DONE.
- done  out  1  high in DONE until the next start or reset.
- error  out  1  sticky until the next start or reset; set on length overflow (or checksum mismatch, see Optional Feature).

Behaviour:
- Reset (async, any state): FSM returns to IDLE. All outputs are 0; internal counters, address, and shift register are cleared. A load interrupted by reset is abandoned; no mem_we is issued after reset asserts.
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little endian), then N×4 data bytes with the LSB first per word.
- States:
  - IDLE: byte_ready=0. On start → LEN_LO; cpu_hold=1 and error=0 from the next cycle.
  - LEN_LO: byte_ready=1. On transfer, latch N[7:0] → LEN_HI.
  - LEN_HI: byte_ready=1. On transfer, latch N[15:8], then:
    - N=0 → DONE.
    - N>MAX_WORDS → error=1, DONE (no writes).
    - otherwise → DATA, with word counter=0 and addr=0.
  - DATA: byte_ready=1. Each transfer shifts the byte into position byte_idx (0..3). The 4th transfer → WRITE.
  - WRITE: byte_ready=0. mem_we=1 for exactly one cycle with mem_addr=addr and mem_wdata=the assembled word. Then:
    - addr += 4, count += 1.
    - If count==N → DONE (or CHECK with the optional feature); else → DATA.
  - DONE: done=1, cpu_hold=0, busy=0, byte_ready=0. start → LEN_LO (re-load).
- Latency and throughput:
  - mem_we asserts exactly 1 cycle after the transfer of the 4th byte of a word.
  - Maximum throughput is 1 word per 5 cycles.
- mem_addr and mem_wdata are registered and hold their last value when mem_we=0.
- Address arithmetic is ADDR_WIDTH bits. Wrap cannot occur because N≤MAX_WORDS is enforced.
- byte_valid without byte_ready: the byte is not consumed, and the host must hold it.
- start asserted while busy is ignored; no state change.
- byte_valid in IDLE/DONE: byte_ready=0, nothing happens.
- Gaps (byte_valid=0) in any receive state: the FSM waits indefinitely; partial word state is retained.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, go to state CHECK (byte_ready=1) and accept one byte.
  - Compare it with the XOR of all N×4 data bytes.
  - Mismatch → error=1. Either way → DONE.
  - For N=0, the checksum byte is still expected and must equal 0x00. For N>MAX_WORDS, no checksum byte is consumed.
- Undefined: no CHECK state; the FSM goes from the last WRITE directly to DONE, and error is set only by length overflow.

Test Plan:
- Reset values: assert reset mid-DATA after 2 bytes → all outputs 0 immediately. Deassert, start, then load N=1 with bytes 13 01 50 00 → mem_we once at addr 0, data 0x00500113.
- Multi-word load: N=3 with words 0x00500113, 0x00C00193, 0xFF718393 → writes at addr 0, 4, 8 in order. done=1 and cpu_hold=0 after the third write; cpu_hold=1 throughout the load.
- Backpressure and gaps: random byte_valid gaps with N=2 → identical writes, each mem_we exactly 1 cycle after the 4th byte transfer; byte_ready=0 during WRITE.
- Boundaries:
  - N=0 → DONE with no mem_we.
  - N=513 → error=1, DONE, no mem_we.
  - N=512 → last write at addr 2044.
- start pulsed during DATA → ignored. start in DONE → new load restarts at addr 0 with error cleared.
- With IMEM_LOADER_CHECKSUM_EN, N=1 word 0x00500113:
  - checksum 0x42 (13^01^50^00) → error=0.
  - checksum 0x00 → error=1.
